// File: rtl/muldiv_seq.sv
// Iterative 16-bit shift-add multiplier / restoring divider writing Lo/Hi to a register file.
// Define MULDIV_SIGNED_EN to enable two's-complement operation selected by op[1].
module muldiv_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ITER  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       dest,
    output logic             busy,
    output logic             write_enable,
    output logic [3:0]       select_input,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic             done
);
    localparam int unsigned CW = $clog2(ITER);

    typedef enum logic [1:0] {StIdle, StCalc, StWbLo, StWbHi} state_e;
    state_e state_q, state_d;

    logic             is_div_q, dz_q;
    logic [WIDTH-1:0] a_q, opnd_q, hi_q, lo_q;
    logic [3:0]       dest_q;
    logic [CW-1:0]    cnt_q;
    logic             last_iter;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] step_hi, step_lo, fix_hi, fix_lo;
    logic [WIDTH:0]   sum, rem_sh, trial;

    assign last_iter = (cnt_q == CW'(ITER - 1));

`ifdef MULDIV_SIGNED_EN
    logic neg_lo_q, neg_hi_q;
    assign mag_a = (op[1] && a[WIDTH-1]) ? -a : a;
    assign mag_b = (op[1] && b[WIDTH-1]) ? -b : b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            neg_lo_q <= op[1] & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi_q <= op[1] & a[WIDTH-1];
        end
    end
`else
    logic unused_op;
    assign unused_op = op[1];
    assign mag_a = a;
    assign mag_b = b;
`endif

    // One iteration: {hi,lo} is product/multiplier for multiply, remainder/quotient for divide.
    always_comb begin
        sum     = {1'b0, hi_q} + {1'b0, opnd_q};
        rem_sh  = {hi_q, lo_q[WIDTH-1]};
        trial   = rem_sh - {1'b0, opnd_q};
        step_hi = hi_q;
        step_lo = lo_q;
        if (is_div_q) begin
            if (rem_sh >= {1'b0, opnd_q}) begin
                step_hi = trial[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = rem_sh[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else if (lo_q[0]) begin
            {step_hi, step_lo} = {sum, lo_q[WIDTH-1:1]};
        end else begin
            {step_hi, step_lo} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
        end
    end

    // Sign and divide-by-zero fix-up folded into the final CALC edge.
    always_comb begin
        fix_hi = step_hi;
        fix_lo = step_lo;
`ifdef MULDIV_SIGNED_EN
        if (!is_div_q) begin
            if (neg_lo_q) {fix_hi, fix_lo} = -{step_hi, step_lo};
        end else begin
            if (neg_lo_q) fix_lo = -step_lo;
            if (neg_hi_q) fix_hi = -step_hi;
        end
`endif
        if (dz_q) begin
            fix_lo = '1;
            fix_hi = a_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            a_q      <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dest_q   <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        is_div_q <= op[0];
                        dz_q     <= op[0] && (b == '0);
                        a_q      <= a;
                        dest_q   <= dest;
                        cnt_q    <= '0;
                        hi_q     <= '0;
                        lo_q     <= op[0] ? mag_a : mag_b;
                        opnd_q   <= op[0] ? mag_b : mag_a;
                    end
                end
                StCalc: begin
                    cnt_q <= cnt_q + 1'b1;
                    hi_q  <= last_iter ? fix_hi : step_hi;
                    lo_q  <= last_iter ? fix_lo : step_lo;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StCalc;
            StCalc:  if (last_iter) state_d = StWbLo;
            StWbLo:  state_d = StWbHi;
            StWbHi:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy         = (state_q != StIdle);
        write_enable = 1'b0;
        select_input = '0;
        result       = '0;
        div_by_zero  = 1'b0;
        done         = 1'b0;
        case (state_q)
            StWbLo: begin
                write_enable = 1'b1;
                select_input = dest_q;
                result       = lo_q;
                div_by_zero  = dz_q;
            end
            StWbHi: begin
                write_enable = 1'b1;
                select_input = dest_q + 4'd1;
                result       = hi_q;
                div_by_zero  = dz_q;
                done         = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed ops push expected writes, a monitor pops and compares.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [3:0]  dest = '0;
    logic        busy, write_enable, div_by_zero, done;
    logic [3:0]  select_input;
    logic [15:0] result;

    muldiv_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .a            (a),
        .b            (b),
        .dest         (dest),
        .busy         (busy),
        .write_enable (write_enable),
        .select_input (select_input),
        .result       (result),
        .div_by_zero  (div_by_zero),
        .done         (done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0]  sel;
        logic [15:0] data;
        logic        dz;
        logic        hi;
        int unsigned cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && write_enable) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: sel %0d data %h, expected no write", select_input,
                         result);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_sel", 32'(select_input), 32'(mon_e.sel));
                check("wr_data", 32'(result), 32'(mon_e.data));
                check("wr_dz", 32'(div_by_zero), 32'(mon_e.dz));
                check("wr_done", 32'(done), 32'(mon_e.hi));
                check("wr_cycle", cyc, mon_e.cyc);
            end
        end else if (rst_n && (done || div_by_zero || result != 0 || select_input != 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stray_outputs: done %b dz %b res %h sel %0d, expected all zero", done,
                     div_by_zero, result, select_input);
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [15:0] ia, input logic [15:0] ib,
                         input logic [3:0] d, input logic [15:0] lo, input logic [15:0] hi,
                         input logic dz, input int hold);
        int unsigned e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = ia;
        b     = ib;
        dest  = d;
        e     = cyc + 1;
        exp_q.push_back('{d, lo, dz, 1'b0, e + 16});
        exp_q.push_back('{d + 4'd1, hi, dz, 1'b1, e + 17});
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            if (k >= hold) start = 1'b0;
            if (k == 0) begin
                a    = ~ia;
                b    = ib ^ 16'h5a5a;
                dest = ~d;
                op   = ~o;
            end
            check("busy", 32'(busy), 32'(k <= 17));
        end
        start = 1'b0;
    endtask

    task automatic check_idle_zero(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_we"}, 32'(write_enable), 32'd0);
        check({name, "_outs"}, {div_by_zero, done, select_input, result}, 32'd0);
    endtask

    initial begin
        #1;
        check_idle_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(2'b00, 16'h1234, 16'h0010, 4'd3, 16'h2340, 16'h0001, 1'b0, 0);
        do_op(2'b00, 16'hFFFF, 16'hFFFF, 4'd15, 16'h0001, 16'hFFFE, 1'b0, 0);
        do_op(2'b01, 16'd100, 16'd7, 4'd6, 16'h000E, 16'h0002, 1'b0, 0);
        do_op(2'b01, 16'h0042, 16'h0000, 4'd9, 16'hFFFF, 16'h0042, 1'b1, 15);
        do_op(2'b01, 16'hFFFF, 16'h0001, 4'd12, 16'hFFFF, 16'h0000, 1'b0, 0);
`ifdef MULDIV_SIGNED_EN
        do_op(2'b11, 16'hFFF9, 16'h0002, 4'd2, 16'hFFFD, 16'hFFFF, 1'b0, 0);
        do_op(2'b11, 16'h8000, 16'hFFFF, 4'd4, 16'h8000, 16'h0000, 1'b0, 0);
        do_op(2'b10, 16'hFFFF, 16'h0002, 4'd5, 16'hFFFE, 16'hFFFF, 1'b0, 0);
`else
        do_op(2'b11, 16'hFFF9, 16'h0002, 4'd2, 16'h7FFC, 16'h0001, 1'b0, 0);
        do_op(2'b11, 16'h8000, 16'hFFFF, 4'd4, 16'h0000, 16'h8000, 1'b0, 0);
        do_op(2'b10, 16'hFFFF, 16'h0002, 4'd5, 16'hFFFE, 16'h0001, 1'b0, 0);
`endif

        // Reset during CALC cycle 5, released in cycle 8: no writes may follow.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a     = 16'h0003;
        b     = 16'h0005;
        dest  = 4'd1;
        @(negedge clk);
        start = 1'b0;
        check("pre_reset_busy", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_zero("mid_reset");
        repeat (3) @(negedge clk);
        check_idle_zero("held_reset");
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("post_reset_busy", 32'(busy), 32'd0);
        end

        do_op(2'b00, 16'h0003, 16'h0005, 4'd1, 16'h000F, 16'h0000, 1'b0, 0);

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative 16-bit multiply/divide unit sitting directly downstream of the register file's A/B read ports and upstream of its write port. It captures two operands and a destination register index on a Start pulse, computes over 16 cycles, then drives the register file write port for two consecutive cycles. The low word or quotient goes to Dest; the high word or remainder goes to Dest+1. A Done pulse marks completion. The design is one clock domain and needs no stall logic inside the register file.

## Interface
Parameters:
- WIDTH, 16, operand and result-word width; fixed at 16 for this design.
- ITER, 16, number of CALC iterations; must equal WIDTH.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE.
- Op  in  2  bit0: 0=multiply, 1=divide; bit1: 1=signed (see Configuration).
- A  in  16  multiplicand / dividend; captured with Start.
- B  in  16  multiplier / divisor; captured with Start.
- Dest  in  4  destination register index; captured with Start.
- Busy  out  1  high in any state other than IDLE.
- WriteEnable  out  1  register file write strobe.
- SelectInput  out  4  register file write index.
- Result  out  16  register file write data.
- DivByZero  out  1  high during both writeback cycles of a divide with B=0.
- Done  out  1  one-cycle pulse, coincident with WB_HI.

## Operation
- States: IDLE → CALC (exactly 16 cycles, iteration counter 0..15) → WB_LO → WB_HI → IDLE. There are no other transitions except reset.
- IDLE: if Start=1 at a rising edge, latch Op/A/B/Dest, clear the accumulator, go to CALC. Start is ignored in every other state; there is no queueing.
- Multiply: shift-add, one multiplier bit per CALC cycle, 32-bit product. Lo = product[15:0], Hi = product[31:16].
- Divide: restoring shift-subtract, one quotient bit per CALC cycle. Lo = quotient, Hi = remainder.
- Divide by zero: still takes 16 CALC cycles. Quotient = 16'hFFFF, remainder = captured A, DivByZero=1 in WB_LO and WB_HI.
- WB_LO: WriteEnable=1, SelectInput=Dest, Result=Lo.
- WB_HI: WriteEnable=1, SelectInput=(Dest+1) mod 16, Result=Hi, Done=1.
- Dest=15 wraps, so Hi/remainder is written to register 0.
- Outside WB_LO/WB_HI: WriteEnable=0, SelectInput=0, Result=0, DivByZero=0, Done=0.
- Operand changes on A/B/Dest after capture have no effect on the operation in progress.

## Timing
- Edge 0: Start is accepted. CALC occupies cycles 1–16, WB_LO is cycle 17, WB_HI is cycle 18, IDLE resumes at cycle 19.
- The earliest next Start is accepted at the edge ending cycle 19. Sustained throughput is one operation per 19 cycles.
- Busy is registered: 0 in cycle 0, 1 in cycles 1–18, 0 from cycle 19.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- Reset (asynchronous, active-low) at any time forces IDLE. All outputs go to 0 immediately and internal registers are cleared.
- An operation interrupted by reset produces no writes and no Done, including when reset arrives during WB_LO.
- Reset release while Start=1: Start is honoured at the first rising edge with Reset high.

## Configuration
- MULDIV_SIGNED_EN defined:
  - Op[1]=1 selects two's-complement operation. Magnitudes are computed in CALC and the sign fix-up is applied on the CALC→WB_LO edge, so latency is unchanged.
  - Signed quotient sign = sign(A) xor sign(B). Remainder sign = sign(A).
  - Signed product is the full 32-bit two's-complement result.
  - 16'h8000 / 16'hFFFF gives quotient 16'h8000, remainder 0.
  - Signed divide by zero gives quotient 16'hFFFF, remainder = A.
- MULDIV_SIGNED_EN not defined: Op[1] is ignored and all operations are unsigned. No sign logic is synthesised.

## Test plan
- Unsigned multiply: Op=00, A=16'h1234, B=16'h0010, Dest=3, Start at cycle 0 → cycle 17 writes R3=16'h2340; cycle 18 writes R4=16'h0001 with Done=1; Busy=0 at cycle 19.
- Wrap-around: Op=00, A=B=16'hFFFF, Dest=15 → R15=16'h0001, then R0=16'hFFFE.
- Unsigned divide: Op=01, A=100, B=7, Dest=6 → R6=16'h000E, R7=16'h0002, DivByZero=0.
- Divide by zero: Op=01, A=16'h0042, B=0 → Lo=16'hFFFF, Hi=16'h0042, DivByZero=1 in both writeback cycles. A second Start held high during Busy is ignored.
- Signed divide: Op=11, A=16'hFFF9 (-7), B=2.
  - With MULDIV_SIGNED_EN → Lo=16'hFFFD, Hi=16'hFFFF.
  - Without it → Lo=16'h7FFC, Hi=16'h0001.
- Reset mid-operation: Reset low at cycle 5 of CALC, released at cycle 8 → WriteEnable and Done never assert, all outputs are 0. A new Start then completes normally in 19 cycles.
